// File: rtl/mm2s_ctrl.sv
// MM2S transfer controller: splits a byte-length read command into AXI4 bursts
// that stay inside 4 KB pages, and forwards R beats to AXI-Stream with end-of-transfer tkeep/tlast.
module mm2s_ctrl #(
  parameter int MAX_BURST_BEATS = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [22:0] cmd_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic        m_axi_rvalid,
  input  logic        m_axi_rlast,
  output logic        m_axi_rready,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);
  localparam logic [3:0]  OUT_LIM   = 4'(MAX_OUTSTANDING);
  localparam logic [20:0] BURST_LIM = 21'(MAX_BURST_BEATS);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t      state_q, state_d;
  logic        ready_en_q;
  logic [31:0] addr_q, addr_d;
  logic [20:0] beats_left_q, beats_left_d;
  logic [20:0] rx_left_q, rx_left_d;
  logic [3:0]  last_keep_q, last_keep_d;
  logic [8:0]  burst_q, burst_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [3:0]  outst_q, outst_d;

  logic        steer, rx_acc, ar_hs;
  logic [10:0] page_room;
  logic [20:0] bmin, len_beats;

  assign steer     = (state_q == S_CALC) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign rx_acc    = steer && m_axi_rvalid && m_axis_tready;
  assign ar_hs     = m_axi_arvalid && m_axi_arready;
  assign len_beats = cmd_len[22:2] + {20'd0, (cmd_len[1:0] != 2'b00)};
  // addr is word aligned, so the room left in the 4 KB page in beats is exact
  assign page_room = 11'd1024 - {1'b0, addr_q[11:2]};

  assign cmd_ready     = (state_q == S_IDLE) && ready_en_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = (state_q == S_ISSUE) && (outst_q < OUT_LIM);
  assign m_axi_rready  = steer && m_axis_tready;
  assign m_axis_tvalid = steer && m_axi_rvalid;
  assign m_axis_tdata  = steer ? m_axi_rdata : 32'd0;
  assign m_axis_tlast  = steer && (rx_left_q == 21'd1);
  assign m_axis_tkeep  = !steer ? 4'h0 : (rx_left_q == 21'd1) ? last_keep_q : 4'hF;

  always_comb begin
    bmin = beats_left_q;
    if (bmin > BURST_LIM) bmin = BURST_LIM;
    if (bmin > {10'd0, page_room}) bmin = {10'd0, page_room};
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    rx_left_d    = rx_left_q;
    last_keep_d  = last_keep_q;
    burst_d      = burst_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    outst_d      = outst_q;

    if (rx_acc && rx_left_q != 21'd0) rx_left_d = rx_left_q - 21'd1;

    case ({ar_hs, rx_acc && m_axi_rlast})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        if (cmd_len == 23'd0 || cmd_addr[1:0] != 2'b00) begin
          state_d = S_ERR;
        end else begin
          addr_d       = cmd_addr;
          beats_left_d = len_beats;
          rx_left_d    = len_beats;
          case (cmd_len[1:0])
            2'd1:    last_keep_d = 4'b0001;
            2'd2:    last_keep_d = 4'b0011;
            2'd3:    last_keep_d = 4'b0111;
            default: last_keep_d = 4'b1111;
          endcase
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        burst_d  = bmin[8:0];
        araddr_d = addr_q;
        arlen_d  = bmin[7:0] - 8'd1;  // 256 wraps to 0, giving arlen 255
        state_d  = S_ISSUE;
      end
      S_ISSUE: if (ar_hs) begin
        addr_d       = addr_q + {21'd0, burst_q, 2'b00};
        beats_left_d = beats_left_q - {12'd0, burst_q};
        state_d      = (beats_left_d == 21'd0) ? S_DRAIN : S_CALC;
      end
      S_DRAIN: if (rx_left_q == 21'd0 || (rx_acc && rx_left_q == 21'd1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_en_q   <= 1'b0;
      addr_q       <= '0;
      beats_left_q <= '0;
      rx_left_q    <= '0;
      last_keep_q  <= '0;
      burst_q      <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      outst_q      <= '0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      rx_left_q    <= rx_left_d;
      last_keep_q  <= last_keep_d;
      burst_q      <= burst_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      outst_q      <= outst_d;
    end
  end
endmodule
